sevenseg_reader: RTL and testbench

Receive-side decoder for the multiplexed four-digit, active-low seven-segment display bus. It samples the segment and digit-select lines, waits for each digit to be stable, and inverts the hex-to-segment encoding back to a 4-bit nibble per digit. It then assembles a 16-bit value with frame-complete and error status. It sits on the board-test and loopback path, observing the bus produced by the display driver, so that displayed values can be checked in hardware and in simulation.

---
 rtl/sevenseg_pkg.sv | 49 ++++
 rtl/sevenseg_reader_if.sv | 22 ++
 rtl/sevenseg_pattern_decode.sv | 34 +++
 rtl/sevenseg_reader.sv | 139 +++++++++++++
 tb/tb_sevenseg_reader.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the active-low seven-segment display bus (encoder and reader sides).
// Segment codes are written g..a (bit 6 down to bit 0); a 0 lights the segment.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_decode_t;

  // Position of the single set bit; callers qualify one-hotness separately.
  function automatic logic [1:0] digit_index(input logic [3:0] hot);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (hot[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_reader_if.sv
// Observation bus between a seven-segment display driver (master) and the reader (slave).
// No handshake: seg/dig_n are free-running display lines; status outputs are single-cycle pulses or levels.
interface sevenseg_reader_if;
  logic [6:0]  seg;
  logic [3:0]  dig_n;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        value_valid;
  logic        frame_done;
  logic        pattern_err;
  logic        stale;

  modport master (
    output seg, dig_n,
    input  value, digit_valid, value_valid, frame_done, pattern_err, stale
  );

  modport slave (
    input  seg, dig_n,
    output value, digit_valid, value_valid, frame_done, pattern_err, stale
  );
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: seg pattern -> {legal, blank, nibble}.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0]  seg_i,
  output seg_decode_t dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.legal = 1'b1;
    dec_o.blank = (seg_i == SEG_BLANK);
    case (seg_i)
      SEG_0:   dec_o.nibble = 4'h0;
      SEG_1:   dec_o.nibble = 4'h1;
      SEG_2:   dec_o.nibble = 4'h2;
      SEG_3:   dec_o.nibble = 4'h3;
      SEG_4:   dec_o.nibble = 4'h4;
      SEG_5:   dec_o.nibble = 4'h5;
      SEG_6:   dec_o.nibble = 4'h6;
      SEG_7:   dec_o.nibble = 4'h7;
      SEG_8:   dec_o.nibble = 4'h8;
      SEG_9:   dec_o.nibble = 4'h9;
      SEG_A:   dec_o.nibble = 4'hA;
      SEG_B:   dec_o.nibble = 4'hB;
      SEG_C:   dec_o.nibble = 4'hC;
      SEG_D:   dec_o.nibble = 4'hD;
      SEG_E:   dec_o.nibble = 4'hE;
      SEG_F:   dec_o.nibble = 4'hF;
      default: dec_o.legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Seven-segment bus reader: debounces each digit dwell, decodes it and assembles a 16-bit value.
// Define SEVENSEG_READER_BLANK_EN to accept the all-off pattern as a legal blank digit.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  sevenseg_reader_if.slave  bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]        STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_HELD = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [6:0]        seg_q, seg_prev_q;
  logic [3:0]        dig_q, dig_prev_q;
  logic [7:0]        stab_q, stab_d;
  logic              dwell_q, dwell_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [3:0]        seen_q, seen_d;
  logic [15:0]       value_q, value_d;
  logic [3:0]        digit_valid_q, digit_valid_d;
  logic              value_valid_q, value_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              pattern_err_q, pattern_err_d;
  logic              stale_q, stale_d;

  logic              sel_ok, hold, capture, blank_ok, accept;
  logic [1:0]        k;
  logic [3:0]        seen_set;
  seg_decode_t       dec;

  sevenseg_pattern_decode u_decode (
    .seg_i (seg_q),
    .dec_o (dec)
  );

  assign sel_ok   = $onehot(~dig_q);
  assign hold     = sel_ok && (seg_q == seg_prev_q) && (dig_q == dig_prev_q);
  assign capture  = hold && (stab_q == STAB_LAST) && !dwell_q;
  assign k        = digit_index(~dig_q);
  assign seen_set = seen_q | (4'b0001 << k);

`ifdef SEVENSEG_READER_BLANK_EN
  assign blank_ok = dec.blank;
`else
  assign blank_ok = 1'b0;
`endif

  assign accept = dec.legal || blank_ok;

  always_comb begin
    stab_d        = hold ? ((stab_q == STAB_LAST) ? stab_q : stab_q + 8'd1) : 8'd0;
    dwell_d       = hold && (dwell_q || capture);
    idle_d        = idle_q;
    seen_d        = seen_q;
    value_d       = value_q;
    digit_valid_d = digit_valid_q;
    value_valid_d = value_valid_q;
    frame_done_d  = 1'b0;
    pattern_err_d = 1'b0;
    stale_d       = 1'b0;

    // A capture in the same cycle as the timeout wins and restarts the idle count.
    if (capture) begin
      idle_d = '0;
      if (dec.legal) begin
        value_d[4*k +: 4] = dec.nibble;
        digit_valid_d[k]  = 1'b1;
        seen_d            = seen_set;
      end else if (blank_ok) begin
        digit_valid_d[k]  = 1'b0;
        seen_d            = seen_set;
      end else begin
        digit_valid_d[k]  = 1'b0;
        pattern_err_d     = 1'b1;
      end
      if (accept && (seen_set == 4'hF)) begin
        frame_done_d  = 1'b1;
        value_valid_d = 1'b1;
        seen_d        = '0;
      end
    end else if (idle_q == IDLE_LAST) begin
      stale_d       = 1'b1;
      value_valid_d = 1'b0;
      seen_d        = '0;
      idle_d        = IDLE_HELD;
    end else if (idle_q != IDLE_HELD) begin
      idle_d = idle_q + IDLE_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q         <= '0;
      dig_q         <= '0;
      seg_prev_q    <= '0;
      dig_prev_q    <= '0;
      stab_q        <= '0;
      dwell_q       <= 1'b0;
      idle_q        <= '0;
      seen_q        <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      value_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      seg_q         <= bus.seg;
      dig_q         <= bus.dig_n;
      seg_prev_q    <= seg_q;
      dig_prev_q    <= dig_q;
      stab_q        <= stab_d;
      dwell_q       <= dwell_d;
      idle_q        <= idle_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      digit_valid_q <= digit_valid_d;
      value_valid_q <= value_valid_d;
      frame_done_q  <= frame_done_d;
      pattern_err_q <= pattern_err_d;
      stale_q       <= stale_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.value_valid = value_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader with STABLE_CYCLES=4 and TIMEOUT_CYCLES=16.
module tb_sevenseg_reader;

  localparam int S = 4;
  localparam int T = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sevenseg_reader_if bus ();

  sevenseg_reader #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor, sampled 1 time unit after each rising edge
  int       cyc, fd_cnt, pe_cnt, st_cnt, fd_cyc, st_cyc;
  logic [3:0] fd_dig;
  initial begin
    cyc = 0; fd_cnt = 0; pe_cnt = 0; st_cnt = 0; fd_cyc = 0; st_cyc = 0; fd_dig = '0;
  end
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bus.frame_done)  begin fd_cnt = fd_cnt + 1; fd_cyc = cyc; fd_dig = bus.dig_n; end
    if (bus.pattern_err) pe_cnt = pe_cnt + 1;
    if (bus.stale)       begin st_cnt = st_cnt + 1; st_cyc = cyc; end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
    bus.seg   = s;
    bus.dig_n = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n     = 1'b0;
    bus.seg   = 7'b1111111;
    bus.dig_n = 4'b1111;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_value"}, 32'(bus.value), 32'h0);
    check_eq({tag, "_dv"},    32'(bus.digit_valid), 32'h0);
    check_eq({tag, "_vv"},    32'(bus.value_valid), 32'h0);
    check_eq({tag, "_fd"},    32'(bus.frame_done), 32'h0);
    check_eq({tag, "_pe"},    32'(bus.pattern_err), 32'h0);
    check_eq({tag, "_st"},    32'(bus.stale), 32'h0);
  endtask

  int base_fd, base_pe, base_st;

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // 1: reset with 8 on digit 0 held; capture lands S+1 edges after the first sampling edge
    rst_n     = 1'b0;
    bus.seg   = 7'b0000000;
    bus.dig_n = 4'b1110;
    repeat (3) @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    repeat (S + 1) @(negedge clk);
    check_all_zero("pre_capture");
    @(negedge clk);
    check_eq("first_value", 32'(bus.value), 32'h0008);
    check_eq("first_dv",    32'(bus.digit_valid), 32'h1);

    // 2: full scan 3..0 -> D1F9, frame completes on digit 0
    pulse_reset();
    base_fd = fd_cnt;
    drive(7'b0100001, 4'b0111, 8);
    drive(7'b1111001, 4'b1011, 8);
    drive(7'b0001110, 4'b1101, 8);
    check_eq("vv_before_frame", 32'(bus.value_valid), 32'h0);
    check_eq("fd_before_frame", 32'(fd_cnt - base_fd), 32'h0);
    drive(7'b0011000, 4'b1110, 8);
    check_eq("scan_value", 32'(bus.value), 32'hD1F9);
    check_eq("scan_dv",    32'(bus.digit_valid), 32'hF);
    check_eq("scan_vv",    32'(bus.value_valid), 32'h1);
    check_eq("scan_fd_cnt", 32'(fd_cnt - base_fd), 32'h1);
    check_eq("scan_fd_dig", 32'(fd_dig), 32'hE);

    // 5: timeout 16 cycles after the last capture
    base_st = st_cnt;
    drive(7'b1111111, 4'b1111, 1);
    for (int i = 0; i < 40 && st_cnt == base_st; i++) @(negedge clk);
    check_eq("stale_seen",  32'(st_cnt - base_st), 32'h1);
    check_eq("stale_delay", 32'(st_cyc - fd_cyc), 32'(T));
    check_eq("stale_vv",    32'(bus.value_valid), 32'h0);
    check_eq("stale_value", 32'(bus.value), 32'hD1F9);
    check_eq("stale_dv",    32'(bus.digit_valid), 32'hF);

    // 3: blank pattern on digit 2
    base_pe = pe_cnt;
    drive(7'b1111111, 4'b1011, 8);
`ifdef SEVENSEG_READER_BLANK_EN
    check_eq("blank_pe", 32'(pe_cnt - base_pe), 32'h0);
`else
    check_eq("blank_pe", 32'(pe_cnt - base_pe), 32'h1);
`endif
    check_eq("blank_dv",    32'(bus.digit_valid), 32'hB);
    check_eq("blank_value", 32'(bus.value), 32'hD1F9);

    // 4: too-short dwell and multi-select dwell must not capture
    base_pe = pe_cnt;
    drive(7'b0011001, 4'b1101, 2);
    drive(7'b1111111, 4'b1111, 4);
    check_eq("short_value", 32'(bus.value), 32'hD1F9);
    check_eq("short_dv",    32'(bus.digit_valid), 32'hB);
    drive(7'b0011001, 4'b1100, 20);
    check_eq("multi_value", 32'(bus.value), 32'hD1F9);
    check_eq("multi_dv",    32'(bus.digit_valid), 32'hB);
    check_eq("multi_pe",    32'(pe_cnt - base_pe), 32'h0);
    drive(7'b0011001, 4'b1101, 8);
    check_eq("d1_value", 32'(bus.value), 32'hD149);
    check_eq("d1_dv",    32'(bus.digit_valid), 32'hB);

    // 6: reset one cycle before a capture would fire
    pulse_reset();
    drive(7'b0011000, 4'b0111, 8);
    check_eq("pre_abort_value", 32'(bus.value), 32'h9000);
    bus.seg   = 7'b0000010;
    bus.dig_n = 4'b1110;
    repeat (S + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    check_all_zero("abort_held");
    rst_n = 1'b1;
    repeat (S + 1) @(negedge clk);
    check_eq("post_abort_value", 32'(bus.value), 32'h0);
    @(negedge clk);
    check_eq("recapture_value", 32'(bus.value), 32'h0006);
    check_eq("recapture_dv",    32'(bus.digit_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
